ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; consumes the decode outputs (aluop, alusel, reg1, reg2, wd, wreg).
- Produces the write-back triple that goes to EX/MEM and is fed back combinationally to decode as the EX forwarding path.
- Adds HI/LO handling with MEM/WB forwarding, plus a multi-cycle DIV/DIVU unit that holds the pipeline through a stall request.

---
 rtl/ex_stage_pkg.sv | 40 ++++
 rtl/ex_stage_div_iter.sv | 95 +++++++++
 rtl/ex_stage.sv | 129 ++++++++++++
 tb/tb_ex_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: operation codes, result classes,
// divider states and datapath widths.
package ex_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] ALU_MOVZ = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] ALU_MOVN = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] ALU_MFHI = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] ALU_MTHI = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] ALU_MFLO = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] ALU_MTLO = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] ALU_DIV  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] ALU_DIVU = 8'b0001_1011;

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] SEL_MOVE  = 3'b011;
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed results
// fixed up from magnitudes when the result is presented.
module ex_stage_div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [REG_W-1:0]   opdata1,
  input  logic [REG_W-1:0]   opdata2,
  output logic [2*REG_W-1:0] result,
  output logic               ready
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] rem, quot, divisor;
  logic             neg_quot, neg_rem;
  logic [REG_W:0]   partial, diff;
  logic             ge;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    partial = {rem, quot[REG_W-1]};
    diff    = partial - {1'b0, divisor};
    ge      = ~diff[REG_W];
  end

  always_comb begin
    state_nx = state;
    case (state)
      DIV_FREE: begin
        if (start) state_nx = (opdata2 == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: state_nx = start ? DIV_END : DIV_FREE;
      DIV_ON: begin
        if (!start)               state_nx = DIV_FREE;
        else if (cnt == LAST_CNT) state_nx = DIV_END;
      end
      DIV_END:  state_nx = DIV_FREE;
      default:  state_nx = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        DIV_FREE: begin
          if (start) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= (signed_div && opdata1[REG_W-1]) ? -opdata1 : opdata1;
            divisor  <= (signed_div && opdata2[REG_W-1]) ? -opdata2 : opdata2;
            neg_quot <= signed_div && (opdata1[REG_W-1] ^ opdata2[REG_W-1]);
            neg_rem  <= signed_div && opdata1[REG_W-1];
          end
        end
        DIV_BY_ZERO: begin
          rem      <= '0;
          quot     <= '0;
          neg_quot <= 1'b0;
          neg_rem  <= 1'b0;
        end
        DIV_ON: begin
          rem  <= ge ? diff[REG_W-1:0] : partial[REG_W-1:0];
          quot <= {quot[REG_W-2:0], ge};
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  always_comb begin
    ready  = (state == DIV_END);
    result = {neg_rem ? -rem : rem, neg_quot ? -quot : quot};
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift/move ops, HI/LO access with MEM/WB
// forwarding, and a stalling multi-cycle divide.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      hi_i,
  input  logic [REG_W-1:0]      lo_i,
  input  logic                  mem_whilo_i,
  input  logic [REG_W-1:0]      mem_hi_i,
  input  logic [REG_W-1:0]      mem_lo_i,
  input  logic                  wb_whilo_i,
  input  logic [REG_W-1:0]      wb_hi_i,
  input  logic [REG_W-1:0]      wb_lo_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  whilo_o,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  stallreq_o
);

  logic               is_div, div_start, div_ready;
  logic [2*REG_W-1:0] div_result;
  logic [REG_W-1:0]   hi_eff, lo_eff;
  logic [REG_W-1:0]   logic_res, shift_res, move_res;

  assign is_div    = (aluop_i == ALU_DIV) || (aluop_i == ALU_DIVU);
  assign div_start = is_div && !div_ready;

  ex_stage_div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (aluop_i == ALU_DIV),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  // Youngest in-flight HI/LO write wins over the architectural copy.
  always_comb begin
    hi_eff = hi_i;
    lo_eff = lo_i;
    if (mem_whilo_i) begin
      hi_eff = mem_hi_i;
      lo_eff = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_eff = wb_hi_i;
      lo_eff = wb_lo_i;
    end
  end

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    move_res  = '0;
    case (aluop_i)
      ALU_OR:   logic_res = reg1_i | reg2_i;
      ALU_AND:  logic_res = reg1_i & reg2_i;
      ALU_XOR:  logic_res = reg1_i ^ reg2_i;
      ALU_NOR:  logic_res = ~(reg1_i | reg2_i);
      ALU_SLL:  shift_res = reg2_i << reg1_i[4:0];
      ALU_SRL:  shift_res = reg2_i >> reg1_i[4:0];
      ALU_SRA:  shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      ALU_MFHI: move_res  = hi_eff;
      ALU_MFLO: move_res  = lo_eff;
      ALU_MOVN, ALU_MOVZ: move_res = reg1_i;
      default: ;
    endcase
  end

  // Everything here is combinational so decode sees the EX result in the same cycle.
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i;
      case (alusel_i)
        SEL_LOGIC: wdata_o = logic_res;
        SEL_SHIFT: wdata_o = shift_res;
        SEL_MOVE:  wdata_o = move_res;
        default:   wdata_o = '0;
      endcase
      case (aluop_i)
        ALU_MTHI: begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_eff;
        end
        ALU_MTLO: begin
          whilo_o = 1'b1;
          hi_o    = hi_eff;
          lo_o    = reg1_i;
        end
        ALU_DIV, ALU_DIVU: begin
          if (div_ready) begin
            whilo_o = 1'b1;
            hi_o    = div_result[2*REG_W-1:REG_W];
            lo_o    = div_result[REG_W-1:0];
          end else begin
            stallreq_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expected values are hand-computed.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i, wb_lo_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .mem_whilo_i (mem_whilo_i),
    .mem_hi_i    (mem_hi_i),
    .mem_lo_i    (mem_lo_i),
    .wb_whilo_i  (wb_whilo_i),
    .wb_hi_i     (wb_hi_i),
    .wb_lo_i     (wb_lo_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .stallreq_o  (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one instruction for a full cycle, starting just after the falling edge.
  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg);
    @(negedge clk);
    rst      = 1'b0;
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wreg;
    #1;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic runDiv(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    applyStimulus(op, SEL_ARITH, a, b, 5'd0, 1'b0);
    checkOutput({tag, "_stall0"}, 32'(stallreq_o), 32'd1);
    checkOutput({tag, "_whilo0"}, 32'(whilo_o), 32'd0);
    for (int i = 1; i < stall_cycles; i++) begin
      stepCycle();
      checkOutput({tag, "_stall"}, 32'(stallreq_o), 32'd1);
    end
    stepCycle();
    checkOutput({tag, "_stall_end"}, 32'(stallreq_o), 32'd0);
    checkOutput({tag, "_whilo"}, 32'(whilo_o), 32'd1);
    checkOutput({tag, "_hi"}, hi_o, exp_hi);
    checkOutput({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    rst = 1'b1;
    aluop_i = ALU_OR; alusel_i = SEL_LOGIC;
    reg1_i = 32'h0F0F_0000; reg2_i = 32'h0000_00FF;
    wd_i = 5'd3; wreg_i = 1'b1;
    hi_i = '0; lo_i = '0;
    mem_whilo_i = 1'b0; mem_hi_i = '0; mem_lo_i = '0;
    wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;

    stepCycle();
    checkOutput("rst_wdata", wdata_o, 32'h0);
    checkOutput("rst_wd", 32'(wd_o), 32'h0);
    checkOutput("rst_wreg", 32'(wreg_o), 32'h0);
    checkOutput("rst_stall", 32'(stallreq_o), 32'h0);
    stepCycle();

    applyStimulus(ALU_OR, SEL_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 5'd3, 1'b1);
    checkOutput("or_wdata", wdata_o, 32'h0F0F_00FF);
    checkOutput("or_wd", 32'(wd_o), 32'd3);
    checkOutput("or_wreg", 32'(wreg_o), 32'd1);
    applyStimulus(ALU_AND, SEL_LOGIC, 32'hF0F0_FF00, 32'h0FF0_0FF0, 5'd7, 1'b1);
    checkOutput("and_wdata", wdata_o, 32'h00F0_0F00);
    applyStimulus(ALU_XOR, SEL_LOGIC, 32'hF0F0_FF00, 32'h0FF0_0FF0, 5'd7, 1'b1);
    checkOutput("xor_wdata", wdata_o, 32'hFF00_F0F0);
    applyStimulus(ALU_NOR, SEL_LOGIC, 32'hF0F0_FF00, 32'h0FF0_0FF0, 5'd7, 1'b0);
    checkOutput("nor_wdata", wdata_o, 32'h000F_000F);
    checkOutput("nor_wreg", 32'(wreg_o), 32'd0);

    applyStimulus(ALU_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd9, 1'b1);
    checkOutput("sra_wdata", wdata_o, 32'hF800_0000);
    applyStimulus(ALU_SRL, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd9, 1'b1);
    checkOutput("srl_wdata", wdata_o, 32'h0800_0000);
    applyStimulus(ALU_SLL, SEL_SHIFT, 32'd4, 32'h8000_0001, 5'd9, 1'b1);
    checkOutput("sll_wdata", wdata_o, 32'h0000_0010);

    hi_i = 32'd1; wb_hi_i = 32'd2; mem_hi_i = 32'd3;
    wb_whilo_i = 1'b1; mem_whilo_i = 1'b1;
    applyStimulus(ALU_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    checkOutput("mfhi_mem", wdata_o, 32'd3);
    mem_whilo_i = 1'b0;
    applyStimulus(ALU_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    checkOutput("mfhi_wb", wdata_o, 32'd2);
    wb_whilo_i = 1'b0;
    applyStimulus(ALU_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    checkOutput("mfhi_arch", wdata_o, 32'd1);
    lo_i = 32'h11; wb_lo_i = 32'h22; wb_whilo_i = 1'b1;
    applyStimulus(ALU_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    checkOutput("mflo_wb", wdata_o, 32'h22);
    applyStimulus(ALU_MOVN, SEL_MOVE, 32'h1234_5678, 32'h1, 5'd4, 1'b1);
    checkOutput("movn_wdata", wdata_o, 32'h1234_5678);

    mem_whilo_i = 1'b1; mem_lo_i = 32'h33;
    applyStimulus(ALU_MTHI, SEL_NOP, 32'hAAAA_5555, 32'h0, 5'd0, 1'b0);
    checkOutput("mthi_whilo", 32'(whilo_o), 32'd1);
    checkOutput("mthi_hi", hi_o, 32'hAAAA_5555);
    checkOutput("mthi_lo", lo_o, 32'h33);
    applyStimulus(ALU_MTLO, SEL_NOP, 32'h5555_AAAA, 32'h0, 5'd0, 1'b0);
    checkOutput("mtlo_hi", hi_o, 32'd3);
    checkOutput("mtlo_lo", lo_o, 32'h5555_AAAA);
    mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;

    applyStimulus(8'hFF, SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1);
    checkOutput("unk_wdata", wdata_o, 32'h0);
    checkOutput("unk_whilo", 32'(whilo_o), 32'd0);

    runDiv("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(ALU_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    checkOutput("div_neg_oneshot", 32'(whilo_o), 32'd0);
    checkOutput("div_neg_idle", 32'(stallreq_o), 32'd0);

    runDiv("div_negdivisor", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    runDiv("divu_zero", ALU_DIVU, 32'd100, 32'd0, 2, 32'd0, 32'd0);
    runDiv("divu_b2b", ALU_DIVU, 32'hFFFF_FFFF, 32'h10, 33, 32'hF, 32'h0FFF_FFFF);

    applyStimulus(ALU_DIVU, SEL_ARITH, 32'd9, 32'd3, 5'd0, 1'b0);
    repeat (10) begin
      stepCycle();
      checkOutput("rst_mid_stall", 32'(stallreq_o), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_stall_off", 32'(stallreq_o), 32'd0);
    checkOutput("rst_mid_whilo", 32'(whilo_o), 32'd0);
    checkOutput("rst_mid_lo", lo_o, 32'd0);
    runDiv("divu_after_rst", ALU_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);

    applyStimulus(ALU_DIV, SEL_ARITH, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (4) stepCycle();
    applyStimulus(ALU_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    checkOutput("flush_stall", 32'(stallreq_o), 32'd0);
    checkOutput("flush_whilo", 32'(whilo_o), 32'd0);
    runDiv("div_after_flush", ALU_DIV, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
